// File: rtl/line_pc_mapper_pkg.sv
// asm_map_pkg: shared line kinds, FSM states, ASCII constants and char helpers (LINE_LABEL_EN adds IN_WORD)
package asm_map_pkg;

   typedef enum logic [2:0] {
      LK_BLANK, LK_COMMENT, LK_DATA, LK_INSTR, LK_LABEL, LK_OTHER
   } line_kind_t;

`ifdef LINE_LABEL_EN
   typedef enum logic [1:0] {ST_LINE_START, ST_SKIP_REST, ST_IN_WORD} map_state_t;
`else
   typedef enum logic [1:0] {ST_LINE_START, ST_SKIP_REST} map_state_t;
`endif

   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_SP  = 8'h20;
   localparam logic [7:0] ASCII_TAB = 8'h09;

   function automatic logic is_ident_start(input logic [7:0] c);
      return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_" || c == ".";
   endfunction

endpackage

// File: rtl/line_pc_mapper_counter.sv
// wrap_step_counter: modulo-MAX counter advancing by STEP with a sticky wrap flag
module wrap_step_counter #(
   parameter int MAX  = 256,
   parameter int STEP = 1
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   inc_in,
   input  logic                   clear_in,
   output logic [$clog2(MAX)-1:0] count_out,
   output logic                   wrap_out
);

   localparam int W = $clog2(MAX);

   logic [W-1:0] count_d, count_q;
   logic         wrap_d, wrap_q;
   logic [W:0]   sum;
   logic         wraps;

   // next count: step, fold back to zero at MAX, remember any fold
   always_comb begin
      sum     = {1'b0, count_q} + (W+1)'(STEP);
      wraps   = sum >= (W+1)'(MAX);
      count_d = count_q;
      wrap_d  = wrap_q;
      if (clear_in) begin
         count_d = '0;
         wrap_d  = 1'b0;
      end else if (inc_in) begin
         count_d = wraps ? '0 : sum[W-1:0];
         wrap_d  = wrap_q | wraps;
      end
   end

   // counter state register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count_out = count_q;
   assign wrap_out  = wrap_q;

endmodule

// File: rtl/line_pc_mapper.sv
// line_pc_mapper: classifies streamed source lines and emits {line, pc, kind} records (LINE_LABEL_EN enables labels)
module line_pc_mapper
   import asm_map_pkg::*;
#(
   parameter int NUMBER_LINES = 256,
   parameter int PC_STEP      = 4,
   localparam int LINE_W      = $clog2(NUMBER_LINES),
   localparam int PC_W        = $clog2(NUMBER_LINES * PC_STEP)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              clear_in,
   input  logic              char_valid_in,
   output logic              char_ready_out,
   input  logic [7:0]        char_in,
   output logic              rec_valid_out,
   input  logic              rec_ready_in,
   output logic [LINE_W-1:0] rec_line_out,
   output logic [PC_W-1:0]   rec_pc_out,
   output logic [2:0]        rec_kind_out,
   output logic [PC_W-1:0]   pc_out,
   output logic              line_wrap_out,
   output logic              pc_wrap_out
);

   map_state_t        state_d, state_q;
   line_kind_t        kind_d, kind_q, end_kind, rec_kind_d, rec_kind_q;
   logic              rec_valid_d, rec_valid_q;
   logic [LINE_W-1:0] rec_line_d, rec_line_q, line_idx;
   logic [PC_W-1:0]   rec_pc_d, rec_pc_q, pc;
   logic              take, blank, line_end;

   assign char_ready_out = !rec_valid_q | rec_ready_in;
   assign take           = char_valid_in & char_ready_out & !clear_in & (char_in != ASCII_CR);
   assign blank          = (char_in == ASCII_SP) | (char_in == ASCII_TAB);

   // line classification FSM: first non-blank char picks the kind, LF closes the line
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      line_end = 1'b0;
      end_kind = kind_q;
      if (take) begin
         if (char_in == ASCII_LF) begin
            line_end = 1'b1;
            end_kind = (state_q == ST_LINE_START) ? LK_BLANK : kind_q;
            state_d  = ST_LINE_START;
         end else begin
            case (state_q)
               ST_LINE_START: if (!blank) begin
                  state_d = ST_SKIP_REST;
                  if (char_in == "/" || char_in == ";")
                     kind_d = LK_COMMENT;
                  else if ((char_in >= "0" && char_in <= "9") || char_in == 8'h27)
                     kind_d = LK_DATA;
                  else if (is_ident_start(char_in)) begin
                     kind_d = LK_INSTR;
`ifdef LINE_LABEL_EN
                     state_d = ST_IN_WORD;
`endif
                  end else
                     kind_d = LK_OTHER;
               end
`ifdef LINE_LABEL_EN
               ST_IN_WORD: if (char_in == ":") begin
                  kind_d  = LK_LABEL;
                  state_d = ST_SKIP_REST;
               end else if (blank)
                  state_d = ST_SKIP_REST;
`endif
               default: ;
            endcase
         end
      end
      if (clear_in) begin
         state_d = ST_LINE_START;
         kind_d  = LK_BLANK;
      end
   end

   // single record slot: reload on line end, drain on downstream accept
   always_comb begin
      rec_valid_d = rec_valid_q & !rec_ready_in;
      rec_line_d  = rec_line_q;
      rec_pc_d    = rec_pc_q;
      rec_kind_d  = rec_kind_q;
      if (line_end) begin
         rec_valid_d = 1'b1;
         rec_line_d  = line_idx;
         rec_pc_d    = pc;
         rec_kind_d  = end_kind;
      end
      if (clear_in) begin
         rec_valid_d = 1'b0;
         rec_line_d  = '0;
         rec_pc_d    = '0;
         rec_kind_d  = LK_BLANK;
      end
   end

   // FSM, kind latch and record slot registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_LINE_START;
         kind_q      <= LK_BLANK;
         rec_valid_q <= 1'b0;
         rec_line_q  <= '0;
         rec_pc_q    <= '0;
         rec_kind_q  <= LK_BLANK;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         rec_valid_q <= rec_valid_d;
         rec_line_q  <= rec_line_d;
         rec_pc_q    <= rec_pc_d;
         rec_kind_q  <= rec_kind_d;
      end
   end

   wrap_step_counter #(.MAX(NUMBER_LINES), .STEP(1)) u_line (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .inc_in    (line_end),
      .clear_in  (clear_in),
      .count_out (line_idx),
      .wrap_out  (line_wrap_out)
   );

   wrap_step_counter #(.MAX(NUMBER_LINES * PC_STEP), .STEP(PC_STEP)) u_pc (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .inc_in    (line_end && end_kind == LK_INSTR),
      .clear_in  (clear_in),
      .count_out (pc),
      .wrap_out  (pc_wrap_out)
   );

   assign rec_valid_out = rec_valid_q;
   assign rec_line_out  = rec_line_q;
   assign rec_pc_out    = rec_pc_q;
   assign rec_kind_out  = rec_kind_q;
   assign pc_out        = pc;

endmodule

// File: tb/tb_line_pc_mapper.sv
// tb_line_pc_mapper: directed self-checking bench for line_pc_mapper with NUMBER_LINES=4, PC_STEP=4
module tb_line_pc_mapper;
  typedef struct packed {
    logic [1:0] l;
    logic [3:0] p;
    logic [2:0] k;
  } rec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] char_in = 8'h00;
  logic       rec_valid;
  logic       rec_ready = 1'b1;
  logic [1:0] rec_line;
  logic [3:0] rec_pc;
  logic [2:0] rec_kind;
  logic [3:0] pc;
  logic       line_wrap, pc_wrap;
  int   total = 0;
  int   bad = 0;
  rec_t q[$];
  line_pc_mapper #(.NUMBER_LINES(4), .PC_STEP(4)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .clear_in       (clear),
    .char_valid_in  (char_valid),
    .char_ready_out (char_ready),
    .char_in        (char_in),
    .rec_valid_out  (rec_valid),
    .rec_ready_in   (rec_ready),
    .rec_line_out   (rec_line),
    .rec_pc_out     (rec_pc),
    .rec_kind_out   (rec_kind),
    .pc_out         (pc),
    .line_wrap_out  (line_wrap),
    .pc_wrap_out    (pc_wrap)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst_n && rec_valid && rec_ready) q.push_back({rec_line, rec_pc, rec_kind});
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] c);
    int n = 0;
    char_in = c;
    char_valid = 1'b1;
    while (!char_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL send_timeout char=%h ready=%b required=1", c, char_ready);
    end
    @(negedge clk);
    char_valid = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic send_line(input string s);
    send_str(s);
    send(8'h0A);
  endtask
  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    q.delete();
  endtask
  task automatic test_reset();
    total++;
    if ({rec_valid, rec_line, rec_pc, rec_kind, pc, line_wrap, pc_wrap, char_ready} !== 16'h0001) begin
      bad++;
      $display("FAIL reset_state got=%h required=0001",
               {rec_valid, rec_line, rec_pc, rec_kind, pc, line_wrap, pc_wrap, char_ready});
    end
  endtask
  task automatic test_instr();
    do_clear();
    send_str("add x1");
    send(8'h0D);
    send(8'h0A);
    idle(2);
    total++;
    if (q.size() != 1 || q[0] !== rec_t'{2'd0, 4'd0, 3'd3}) begin
      bad++;
      $display("FAIL instr_record n=%0d got=%h required=%h", q.size(), q.size() ? q[0] : rec_t'('0), rec_t'{2'd0, 4'd0, 3'd3});
    end
    total++;
    if (pc !== 4'd4) begin
      bad++;
      $display("FAIL instr_pc got=%0d required=4", pc);
    end
  endtask
  task automatic test_kinds();
    rec_t exp[4] = '{'{2'd0, 4'd0, 3'd0}, '{2'd1, 4'd0, 3'd1}, '{2'd2, 4'd0, 3'd2}, '{2'd3, 4'd0, 3'd5}};
    do_clear();
    send(8'h0A);
    send(8'h2F);
    send(8'h2F);
    send_line(" c");
    send_line("42");
    send(8'h20);
    send(8'h09);
    send_line("#x");
    idle(2);
    total++;
    if (q.size() != 4) begin
      bad++;
      $display("FAIL kinds_count got=%0d required=4", q.size());
    end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL kinds_rec%0d got=%h required=%h", i, q[i], exp[i]);
      end
    end
    total++;
    if (pc !== 4'd0) begin
      bad++;
      $display("FAIL kinds_pc got=%0d required=0", pc);
    end
  endtask
  task automatic test_label();
`ifdef LINE_LABEL_EN
    rec_t exp[2] = '{'{2'd0, 4'd0, 3'd4}, '{2'd1, 4'd0, 3'd3}};
    logic [3:0] exp_pc = 4'd4;
`else
    rec_t exp[2] = '{'{2'd0, 4'd0, 3'd3}, '{2'd1, 4'd4, 3'd3}};
    logic [3:0] exp_pc = 4'd8;
`endif
    do_clear();
    send_line("  loop: add");
    send_line("add");
    idle(2);
    total++;
    if (q.size() != 2) begin
      bad++;
      $display("FAIL label_count got=%0d required=2", q.size());
    end
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL label_rec%0d got=%h required=%h", i, q[i], exp[i]);
      end
    end
    total++;
    if (pc !== exp_pc) begin
      bad++;
      $display("FAIL label_pc got=%0d required=%0d", pc, exp_pc);
    end
  endtask
  task automatic test_backpressure();
    rec_t exp[2] = '{'{2'd0, 4'd0, 3'd3}, '{2'd1, 4'd4, 3'd3}};
    do_clear();
    rec_ready = 1'b0;
    send_line("a");
    char_in = "b";
    char_valid = 1'b1;
    #1;
    total++;
    if (char_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready got=%b required=0", char_ready);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({rec_valid, rec_line, rec_pc, rec_kind} !== {1'b1, 2'd0, 4'd0, 3'd3}) begin
        bad++;
        $display("FAIL bp_hold got=%h required=%h", {rec_valid, rec_line, rec_pc, rec_kind}, {1'b1, 2'd0, 4'd0, 3'd3});
      end
    end
    rec_ready = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    send(8'h0A);
    idle(2);
    total++;
    if (q.size() != 2) begin
      bad++;
      $display("FAIL bp_count got=%0d required=2", q.size());
    end
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL bp_rec%0d got=%h required=%h", i, q[i], exp[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    do_clear();
    char_in = 8'h0A;
    char_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    idle(2);
    total++;
    if (q.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=3", q.size());
    end
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      total++;
      if (q[i] !== rec_t'{2'(i), 4'd0, 3'd0}) begin
        bad++;
        $display("FAIL b2b_rec%0d got=%h required=%h", i, q[i], rec_t'{2'(i), 4'd0, 3'd0});
      end
    end
  endtask
  task automatic test_wrap();
    do_clear();
    repeat (5) send_line("x");
    idle(2);
    total++;
    if (q.size() != 5 || q[4] !== rec_t'{2'd0, 4'd0, 3'd3}) begin
      bad++;
      $display("FAIL wrap_rec4 n=%0d got=%h required=%h", q.size(), q.size() == 5 ? q[4] : rec_t'('0), rec_t'{2'd0, 4'd0, 3'd3});
    end
    total++;
    if ({line_wrap, pc_wrap, pc} !== {1'b1, 1'b1, 4'd4}) begin
      bad++;
      $display("FAIL wrap_flags got=%b%b pc=%0d required=11 pc=4", line_wrap, pc_wrap, pc);
    end
  endtask
  task automatic test_reset_mid();
    q.delete();
    send_str("ab");
    char_in = 8'h0A;
    char_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    char_valid = 1'b0;
    total++;
    if ({rec_valid, rec_line, rec_pc, rec_kind, pc, line_wrap, pc_wrap} !== 15'h0) begin
      bad++;
      $display("FAIL rst_mid_state got=%h required=0", {rec_valid, rec_line, rec_pc, rec_kind, pc, line_wrap, pc_wrap});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h0A);
    idle(2);
    total++;
    if (q.size() != 1 || q[0] !== rec_t'{2'd0, 4'd0, 3'd0}) begin
      bad++;
      $display("FAIL rst_mid_restart n=%0d got=%h required=%h", q.size(), q.size() ? q[0] : rec_t'('0), rec_t'{2'd0, 4'd0, 3'd0});
    end
  endtask
  task automatic test_clear_lf();
    send_line("x");
    idle(2);
    q.delete();
    send_str("y");
    char_in = 8'h0A;
    char_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    char_valid = 1'b0;
    total++;
    if ({rec_valid, rec_line, rec_pc, rec_kind, pc, line_wrap, pc_wrap} !== 15'h0 || q.size() != 0) begin
      bad++;
      $display("FAIL clear_lf_state got=%h n=%0d required=0 n=0", {rec_valid, rec_line, rec_pc, rec_kind, pc, line_wrap, pc_wrap}, q.size());
    end
    send(8'h0A);
    idle(2);
    total++;
    if (q.size() != 1 || q[0] !== rec_t'{2'd0, 4'd0, 3'd0}) begin
      bad++;
      $display("FAIL clear_lf_restart n=%0d got=%h required=%h", q.size(), q.size() ? q[0] : rec_t'('0), rec_t'{2'd0, 4'd0, 3'd0});
    end
  endtask
  initial begin
    idle(2);
    test_reset();
    rst_n = 1'b1;
    idle(1);
    test_reset();
    test_instr();
    test_kinds();
    test_label();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_clear_lf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
